win_ctrl: RTL

WIN_CTRL -- requirements
Module: win_ctrl

---
 rtl/game_pkg.sv | 24 ++
 rtl/frame_tick_gen.sv | 38 +++
 rtl/win_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions.
// Holds the win-sequencer state type, the default frame-count constants used
// by the win screen and a small integer helper for sizing counters.
// No ports (package).
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLASH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RESTART = 2'd3
    } win_state_t;

    // Default frame counts for the win screen; at 60 Hz these are
    // roughly 2 s of blinking, quarter-second blinks and 3 s of hold.
    localparam int unsigned DEF_FLASH_FRAMES = 32'd120;
    localparam int unsigned DEF_BLINK_FRAMES = 32'd15;
    localparam int unsigned DEF_HOLD_FRAMES  = 32'd180;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator.
// Registers vblnk and emits a one-cycle, registered pulse the cycle after a
// rising edge of vblnk has been sampled.
// Ports:
//   clk        - system clock (rising edge)
//   rst        - asynchronous active-high reset
//   vblnk      - vertical blanking from the VGA timing chain
//   frame_tick - one-cycle pulse per vblnk rising edge
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_tick
);

    logic vblnk_q;
    logic frame_tick_q;
    logic frame_tick_d;

    // Rising-edge detect against the previous sample.
    always_comb begin
        frame_tick_d = vblnk & ~vblnk_q;
    end

    // Previous-sample and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vblnk_q      <= vblnk;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/win_ctrl.sv
// Win-screen sequencer.
// After a checkmate it blinks the winner's overlay fill for FLASH_FRAMES
// frames, holds it steady for HOLD_FRAMES frames (skippable with key_ack),
// then issues a one-cycle game_rst pulse and returns to idle.
// Ports:
//   clk, rst               - clock and asynchronous active-high reset
//   white_mate, black_mate - one-cycle checkmate pulses from game logic
//   key_ack                - one-cycle user pulse that ends the hold phase
//   vblnk                  - vertical blanking; rising edge is the frame tick
//   white_win, black_win   - overlay fill requests (registered)
//   game_rst               - one-cycle game restart pulse (registered)
//   busy                   - high whenever the sequencer is not idle (registered)
module win_ctrl
    import game_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = DEF_FLASH_FRAMES,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic white_mate,
    input  logic black_mate,
    input  logic key_ack,
    input  logic vblnk,
    output logic white_win,
    output logic black_win,
    output logic game_rst,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(max_u(FLASH_FRAMES, HOLD_FRAMES) + 32'd1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 32'd1);

    logic frame_tick;

    win_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic           blink_q, blink_d;
    logic           winner_q, winner_d;   // 1 = white, 0 = black
    logic           white_win_q, white_win_d;
    logic           black_win_q, black_win_d;
    logic           game_rst_q, game_rst_d;
    logic           busy_q, busy_d;

    frame_tick_gen u_ftg (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .frame_tick (frame_tick)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            blink_q     <= 1'b0;
            winner_q    <= 1'b0;
            white_win_q <= 1'b0;
            black_win_q <= 1'b0;
            game_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            winner_q    <= winner_d;
            white_win_q <= white_win_d;
            black_win_q <= black_win_d;
            game_rst_q  <= game_rst_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, frame counter, blink phase and winner latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        winner_d = winner_q;
        cnt_inc  = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (white_mate || black_mate) begin
                    state_d  = ST_FLASH;
                    winner_d = white_mate;   // white wins a tie
                    cnt_d    = '0;
                    blink_d  = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FLASH: begin
                if (frame_tick) begin
                    if (cnt_q == FLASH_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        // Toggle each time the new count lands on a blink boundary.
                        if ((32'(cnt_inc) % BLINK_FRAMES) == 32'd0) begin
                            blink_d = ~blink_q;
                        end else begin
                            blink_d = blink_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_HOLD: begin
                if (key_ack || (frame_tick && (cnt_q == HOLD_LAST))) begin
                    state_d = ST_RESTART;
                    cnt_d   = '0;
                end else if (frame_tick) begin
                    cnt_d = cnt_inc;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESTART: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        white_win_d = 1'b0;
        black_win_d = 1'b0;
        game_rst_d  = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_FLASH: begin
                white_win_d = winner_d & blink_d;
                black_win_d = ~winner_d & blink_d;
            end
            ST_HOLD: begin
                white_win_d = winner_d;
                black_win_d = ~winner_d;
            end
            ST_RESTART: begin
                game_rst_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign white_win = white_win_q;
    assign black_win = black_win_q;
    assign game_rst  = game_rst_q;
    assign busy      = busy_q;

endmodule
